tx_core_ctrl: RTL and testbench



---
 rtl/tx_core_ctrl.sv | 178 +++++++++++++++++
 tb/tb_tx_core_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_core_ctrl.sv
// tx_core_ctrl: glitch-free reconfiguration sequencer for tx_core (mute, retune, settle, unmute).
// Optional macro TX_CTRL_STATUS_CNT_EN adds a saturating done_count status output.
module tx_core_ctrl #(
    parameter logic [7:0]    RAMP_STEP     = 8'd4,
    parameter int unsigned   RAMP_DIV      = 4,
    parameter int unsigned   SETTLE_CYCLES = 16,
    parameter int unsigned   CNT_W         = 8,
    localparam int unsigned  PHASE_W       = 16,
    localparam int unsigned  GAIN_W        = 8,
    localparam int unsigned  STATE_W       = 3
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_phase_inc,
    input  logic [GAIN_W-1:0]  cfg_gain,
    input  logic               cfg_bypass,
    output logic [PHASE_W-1:0] dds_phase_inc,
    output logic [GAIN_W-1:0]  output_gain,
    output logic               bypass_enable,
    output logic               busy,
    output logic               cfg_done,
    output logic [STATE_W-1:0] state_dbg
`ifdef TX_CTRL_STATUS_CNT_EN
    ,
    output logic [15:0]        done_count
`endif
);

    localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(RAMP_DIV - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        RAMP_DOWN = 3'd1,
        APPLY     = 3'd2,
        SETTLE    = 3'd3,
        RAMP_UP   = 3'd4
    } state_t;

    typedef struct packed {
        logic [PHASE_W-1:0] phase;
        logic [GAIN_W-1:0]  gain;
        logic               bypass;
    } cfg_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    cfg_t               tgt_q, tgt_d;
    logic [PHASE_W-1:0] phase_d;
    logic [GAIN_W-1:0]  gain_d;
    logic               bypass_d;
    logic               done_d;
    logic               tick;
    logic [GAIN_W-1:0]  fall_gain;
    logic [GAIN_W-1:0]  seek_gain;

    assign cfg_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;
    assign tick      = (cnt_q == DIV_LAST);

    // One ramp step toward zero (mute) and toward the target (unmute or gain-only update).
    always_comb begin
        fall_gain = (output_gain <= RAMP_STEP) ? '0 : output_gain - RAMP_STEP;
        seek_gain = output_gain;
        if (tgt_q.gain > output_gain) begin
            seek_gain = ((tgt_q.gain - output_gain) <= RAMP_STEP) ? tgt_q.gain
                                                                  : output_gain + RAMP_STEP;
        end else if (tgt_q.gain < output_gain) begin
            seek_gain = ((output_gain - tgt_q.gain) <= RAMP_STEP) ? tgt_q.gain
                                                                  : output_gain - RAMP_STEP;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tgt_d    = tgt_q;
        phase_d  = dds_phase_inc;
        gain_d   = output_gain;
        bypass_d = bypass_enable;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    tgt_d.phase  = cfg_phase_inc;
                    tgt_d.gain   = cfg_gain;
                    tgt_d.bypass = cfg_bypass;
                    cnt_d        = '0;
                    if ((cfg_phase_inc == dds_phase_inc) && (cfg_bypass == bypass_enable)) begin
                        state_d = RAMP_UP;
                    end else if (output_gain == '0) begin
                        state_d = APPLY;
                    end else begin
                        state_d = RAMP_DOWN;
                    end
                end
            end
            RAMP_DOWN: begin
                if (output_gain == '0) begin
                    state_d = APPLY;
                    cnt_d   = '0;
                end else if (tick) begin
                    gain_d = fall_gain;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            APPLY: begin
                phase_d  = tgt_q.phase;
                bypass_d = tgt_q.bypass;
                cnt_d    = '0;
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = RAMP_UP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RAMP_UP: begin
                if (output_gain == tgt_q.gain) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (tick) begin
                    gain_d = seek_gain;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            tgt_q         <= '0;
            dds_phase_inc <= '0;
            output_gain   <= '0;
            bypass_enable <= 1'b0;
            cfg_done      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tgt_q         <= tgt_d;
            dds_phase_inc <= phase_d;
            output_gain   <= gain_d;
            bypass_enable <= bypass_d;
            cfg_done      <= done_d;
        end
    end

`ifdef TX_CTRL_STATUS_CNT_EN
    // Completed-request counter, sticks at all-ones.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            done_count <= '0;
        end else if (cfg_done && (done_count != 16'hFFFF)) begin
            done_count <= done_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tx_core_ctrl.sv
// Bench for tx_core_ctrl: directed table, handshake/reset sequences, and random requests
// checked cycle by cycle against a segment-based trace model (defaults: step 4, div 4, settle 16).
module tb_tx_core_ctrl;

    localparam int STEP_I   = 4;
    localparam int DIV_I    = 4;
    localparam int SETTLE_I = 16;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [15:0] cfg_phase_inc = '0;
    logic [7:0]  cfg_gain = '0;
    logic        cfg_bypass = 1'b0;
    logic [15:0] dds_phase_inc;
    logic [7:0]  output_gain;
    logic        bypass_enable;
    logic        busy;
    logic        cfg_done;
    logic [2:0]  state_dbg;
`ifdef TX_CTRL_STATUS_CNT_EN
    logic [15:0] done_count;
`endif

    tx_core_ctrl dut (
        .clock        (clock),
        .resetn       (resetn),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_phase_inc(cfg_phase_inc),
        .cfg_gain     (cfg_gain),
        .cfg_bypass   (cfg_bypass),
        .dds_phase_inc(dds_phase_inc),
        .output_gain  (output_gain),
        .bypass_enable(bypass_enable),
        .busy         (busy),
        .cfg_done     (cfg_done),
`ifdef TX_CTRL_STATUS_CNT_EN
        .done_count   (done_count),
`endif
        .state_dbg    (state_dbg)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]  st;
        logic [7:0]  gain;
        logic [15:0] phase;
        logic        byp;
        logic        done;
    } exp_t;

    typedef struct {
        logic [15:0] ph;
        logic [7:0]  g;
        logic        b;
        int          done_at;
        logic [7:0]  fin_gain;
        logic [15:0] fin_phase;
        logic        fin_byp;
    } vec_t;

    exp_t        exp_q[$];
    logic [15:0] m_phase = '0;
    logic [7:0]  m_gain = '0;
    logic        m_byp = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          n_done = 0;

    function automatic logic [7:0] step_toward(input logic [7:0] g, input logic [7:0] t);
        int diff;
        diff = int'(t) - int'(g);
        if (diff > STEP_I) return 8'(int'(g) + STEP_I);
        if (diff < -STEP_I) return 8'(int'(g) - STEP_I);
        return t;
    endfunction

    task automatic push(input logic [2:0] st, input logic [7:0] g, input logic [15:0] ph,
                        input logic b, input logic d);
        exp_t e;
        e.st = st; e.gain = g; e.phase = ph; e.byp = b; e.done = d;
        exp_q.push_back(e);
    endtask

    // A ramp holds each level for DIV cycles, then shows the final level once before leaving.
    task automatic push_ramp(input logic [2:0] st, input logic [7:0] from, input logic [7:0] to,
                             input logic [15:0] ph, input logic b);
        logic [7:0] g;
        g = from;
        while (g != to) begin
            repeat (DIV_I) push(st, g, ph, b, 1'b0);
            g = step_toward(g, to);
        end
        push(st, g, ph, b, 1'b0);
    endtask

    // Expected per-cycle outputs from the cycle after acceptance through the done pulse.
    task automatic build_trace(input logic [15:0] ph, input logic [7:0] g, input logic b);
        exp_q.delete();
        if (ph == m_phase && b == m_byp) begin
            push_ramp(3'd4, m_gain, g, m_phase, m_byp);
        end else begin
            if (m_gain != 8'd0) push_ramp(3'd1, m_gain, 8'd0, m_phase, m_byp);
            push(3'd2, 8'd0, m_phase, m_byp, 1'b0);
            repeat (SETTLE_I) push(3'd3, 8'd0, ph, b, 1'b0);
            push_ramp(3'd4, 8'd0, g, ph, b);
        end
        push(3'd0, g, ph, b, 1'b1);
        m_phase = ph; m_gain = g; m_byp = b;
    endtask

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", tag, act, want);
        end
    endtask

    task automatic cmp_cycle(input string tag, input int idx, input exp_t e);
        logic eb;
        eb = (e.st != 3'd0);
        checks++;
        if (state_dbg !== e.st || output_gain !== e.gain || dds_phase_inc !== e.phase ||
            bypass_enable !== e.byp || cfg_done !== e.done || busy !== eb || cfg_ready !== !eb) begin
            failures++;
            $display("FAIL %s[%0d]: got st=%0d gain=%0d ph=%h byp=%b done=%b busy=%b rdy=%b, want st=%0d gain=%0d ph=%h byp=%b done=%b",
                     tag, idx, state_dbg, output_gain, dds_phase_inc, bypass_enable, cfg_done, busy,
                     cfg_ready, e.st, e.gain, e.phase, e.byp, e.done);
        end
    endtask

    task automatic idle_cycle(input string tag);
        exp_t e;
        @(negedge clock);
        e.st = 3'd0; e.gain = m_gain; e.phase = m_phase; e.byp = m_byp; e.done = 1'b0;
        cmp_cycle(tag, 0, e);
    endtask

    task automatic follow(input string tag, output int done_at);
        done_at = -1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clock);
            cmp_cycle(tag, k, exp_q[k]);
            if (cfg_done === 1'b1 && done_at < 0) done_at = k;
        end
        if (done_at >= 0) n_done++;
    endtask

    task automatic drive(input logic [15:0] ph, input logic [7:0] g, input logic b);
        cfg_phase_inc = ph; cfg_gain = g; cfg_bypass = b; cfg_valid = 1'b1;
    endtask

    // Present one request at a negedge in IDLE; junk on the bus afterwards must be ignored.
    task automatic run_req(input string tag, input logic [15:0] ph, input logic [7:0] g,
                           input logic b, output int done_at);
        check_val({tag, "_ready"}, 32'(cfg_ready), 32'd1);
        build_trace(ph, g, b);
        drive(ph, g, b);
        @(posedge clock);
        #1;
        cfg_valid = 1'b0;
        cfg_phase_inc = 16'($urandom);
        cfg_gain = 8'($urandom);
        cfg_bypass = 1'($urandom);
        follow(tag, done_at);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run exceeded time limit, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl[6];
        int          d;
        int          found;
        int          done_seen;
        logic [15:0] ph;
        logic [7:0]  g;
        logic        b;

        tbl[0] = '{16'h1000, 8'd20, 1'b0, 38, 8'd20, 16'h1000, 1'b0};
        tbl[1] = '{16'h2000, 8'd10, 1'b0, 51, 8'd10, 16'h2000, 1'b0};
        tbl[2] = '{16'h2000, 8'd20, 1'b0, 13, 8'd20, 16'h2000, 1'b0};
        tbl[3] = '{16'h2000, 8'd7,  1'b0, 17, 8'd7,  16'h2000, 1'b0};
        tbl[4] = '{16'h2000, 8'd0,  1'b1, 27, 8'd0,  16'h2000, 1'b1};
        tbl[5] = '{16'h2000, 8'd0,  1'b1, 1,  8'd0,  16'h2000, 1'b1};

        repeat (3) @(negedge clock);
        check_val("reset_state", 32'({state_dbg, output_gain, dds_phase_inc, bypass_enable,
                                      cfg_done, busy, cfg_ready}), 32'd1);
        resetn = 1'b1;
        idle_cycle("post_reset");

        foreach (tbl[i]) begin
            run_req($sformatf("tbl%0d", i), tbl[i].ph, tbl[i].g, tbl[i].b, d);
            check_val($sformatf("tbl%0d_done_at", i), 32'(d), 32'(tbl[i].done_at));
            check_val($sformatf("tbl%0d_final", i), 32'({output_gain, dds_phase_inc, bypass_enable}),
                      32'({tbl[i].fin_gain, tbl[i].fin_phase, tbl[i].fin_byp}));
            idle_cycle($sformatf("tbl%0d_idle", i));
        end

        // cfg_valid stays high with new data through a whole request: no relatch, then back-to-back accept.
        check_val("hs_ready", 32'(cfg_ready), 32'd1);
        build_trace(16'h3456, 8'd24, 1'b0);
        drive(16'h3456, 8'd24, 1'b0);
        @(posedge clock);
        #1;
        cfg_phase_inc = 16'h7777; cfg_gain = 8'd99; cfg_bypass = 1'b1;
        follow("hs_first", d);
        check_val("hs_first_done", 32'(d), 32'(exp_q.size() - 1));
        build_trace(16'h7777, 8'd99, 1'b1);
        @(posedge clock);
        #1;
        cfg_valid = 1'b0;
        follow("hs_second", d);
        idle_cycle("hs_idle");

        for (int n = 0; n < 25; n++) begin
            ph = ($urandom_range(0, 2) == 0) ? 16'($urandom) : m_phase;
            b  = ($urandom_range(0, 3) == 0) ? ~m_byp : m_byp;
            g  = 8'($urandom);
            repeat ($urandom_range(0, 2)) idle_cycle("rnd_gap");
            run_req($sformatf("rnd%0d", n), ph, g, b, d);
        end
        idle_cycle("rnd_idle");

`ifdef TX_CTRL_STATUS_CNT_EN
        check_val("done_count", 32'(done_count), 32'(n_done));
        force dut.done_count = 16'hFFFF;
        @(negedge clock);
        release dut.done_count;
        run_req("sat_req", m_phase, m_gain ^ 8'h10, m_byp, d);
        idle_cycle("sat_idle");
        check_val("done_count_sat", 32'(done_count), 32'h0000FFFF);
`endif

        // Reset in the middle of an unmute ramp.
        drive(m_phase ^ 16'h0101, 8'd60, m_byp);
        @(posedge clock);
        #1;
        cfg_valid = 1'b0;
        found = 0;
        for (int k = 0; k < 3000 && found == 0; k++) begin
            @(negedge clock);
            if (state_dbg == 3'd4 && output_gain == 8'd40) found = 1;
        end
        check_val("rst_reach_gain40", 32'(found), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check_val("rst_async", 32'({state_dbg, output_gain, dds_phase_inc, bypass_enable,
                                    cfg_done, busy, cfg_ready}), 32'd1);
        done_seen = 0;
        repeat (2) begin
            @(negedge clock);
            if (cfg_done !== 1'b0) done_seen = 1;
        end
        resetn = 1'b1;
        m_phase = '0; m_gain = '0; m_byp = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (cfg_done !== 1'b0 || busy !== 1'b0) done_seen = 1;
        end
        check_val("rst_no_done", 32'(done_seen), 32'd0);
        check_val("rst_ready", 32'({cfg_ready, state_dbg, output_gain}), 32'h800);
`ifdef TX_CTRL_STATUS_CNT_EN
        check_val("rst_done_count", 32'(done_count), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
